pipe_skid_buf: RTL and testbench
================================

// Module: pipe_skid_buf
// PURPOSE
// - Two-entry valid/ready skid buffer between pipeline stages. Feeds a downstream flopr-style data register.
// - Decouples upstream "ready" timing from downstream back-pressure without losing or reordering beats.
// - Adds a synchronous flush for branch/exception squash. Registered output; sustains 1 beat/cycle.
// PARAMETERS
// - N  default 32  data width in bits (N >= 1)
// PORTS
// - clk        input   1  single clock; all state updates on posedge clk
// - reset      input   1  synchronous, active-high reset
// - flush      input   1  synchronous squash of all held beats
// - in_valid   input   1  upstream beat present
// - in_ready   output  1  buffer can accept a beat this cycle
// - in_data    input   N  upstream beat payload
// - out_valid  output  1  out_data holds a valid beat
// - out_ready  input   1  downstream takes the beat this cycle
// - out_data   output  N  registered payload of the oldest held beat
// BEHAVIOUR
// - Handshakes: accept = in_valid & in_ready; take = out_valid & out_ready. Both evaluated at posedge clk.
// - Storage: out_reg (N, drives out_data) and skid_reg (N).
// - States: EMPTY (no beats), ONE (out_reg full), TWO (out_reg and skid_reg full).
// - Outputs by state:
//   - out_valid = (state != EMPTY).
//   - in_ready = (state != TWO) & !reset.
//   - in_ready depends only on state and reset; no combinational path from out_ready.
// - Transitions when not reset and not flush:
//   - EMPTY: accept -> ONE, out_reg <= in_data; else stay.
//   - ONE: accept & !take -> TWO, skid_reg <= in_data.
//   - ONE: accept & take -> stay ONE, out_reg <= in_data.
//   - ONE: !accept & take -> EMPTY.
//   - ONE: neither -> stay.
//   - TWO: take -> ONE, out_reg <= skid_reg; else stay. No accept is possible (in_ready=0).
// - Latency: accepted beat appears on out_data/out_valid the cycle after acceptance when the buffer was empty.
// - Order: strict FIFO; no beat is duplicated or dropped except by flush/reset.
// - out_data holds its value while out_valid=1 and out_ready=0.
// - out_data when EMPTY: holds the last value; reads as don't-care.
// - Flush:
//   - Next state is EMPTY; out_valid=0 and in_ready=1 the following cycle.
//   - A beat offered in the flush cycle is discarded even though in_ready=1.
//   - A take in the flush cycle still counts as consumed downstream.
// - Reset (priority over flush):
//   - Next state EMPTY. out_reg and skid_reg <= 0, so out_data=0 and out_valid=0.
//   - in_ready=0 while reset=1 and 1 on the first cycle after release.
//   - Mid-operation reset discards all held beats.
// - Full boundary: in TWO with out_ready=0 the buffer holds indefinitely; in_valid is ignored.
// - Empty boundary: out_ready while EMPTY has no effect.
// CONFIGURATION
// - Macro SKID_STATS_EN defined:
//   - Adds output stall_cnt [15:0]: counts cycles with in_valid=1 and in_ready=0 while reset=0.
//   - Saturates at 16'hFFFF. Cleared by reset only, not by flush.
//   - Updates at posedge; reset value 0.
// - Macro undefined: stall_cnt port and counter are absent; all other behaviour identical.
// TESTING
// - Reset: hold reset=1 for 5 cycles with in_valid=1, in_data=7 -> in_ready=0, out_valid=0, out_data=0 throughout.
// - Streaming: send 0..9 back-to-back with out_ready=1 -> out_data 0..9 on consecutive cycles, 1-cycle latency, in_ready stays 1.
// - Back-pressure: out_ready=0, send 3,4 -> state TWO, in_ready=0.
//   - Then out_ready=1 -> outputs 3 then 4, no loss.
// - Simultaneous: in ONE holding 5, accept 6 and take 5 in the same cycle -> next out_data=6, out_valid=1, state ONE.
// - Flush: in TWO holding 8,9, assert flush with in_valid=1, in_data=10 -> next cycle out_valid=0, in_ready=1; 10 never appears.
// - SKID_STATS_EN: hold TWO with in_valid=1 for 20 cycles -> stall_cnt=20.
//   - Then reset -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready skid buffer with registered output and synchronous flush.
// Optional stall counter output enabled by defining SKID_STATS_EN.
module pipe_skid_buf #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data
`ifdef SKID_STATS_EN
   ,
   output logic [15:0]  stall_cnt
`endif
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t         state, state_next;
   logic [N-1:0]   out_reg, skid_reg;
   logic           accept, take;
   logic           load_out_in, load_out_skid, load_skid;

   // in_ready is a function of state and reset only, so out_ready never reaches it
   assign in_ready  = (state != TWO) & ~reset;
   assign out_valid = (state != EMPTY);
   assign out_data  = out_reg;
   assign accept    = in_valid & in_ready;
   assign take      = out_valid & out_ready;

   always_comb begin
      state_next    = state;
      load_out_in   = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
      if (flush) begin
         state_next = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  state_next  = ONE;
                  load_out_in = 1'b1;
               end
            end
            ONE: begin
               if (accept && !take) begin
                  state_next = TWO;
                  load_skid  = 1'b1;
               end else if (accept && take) begin
                  load_out_in = 1'b1;
               end else if (take) begin
                  state_next = EMPTY;
               end
            end
            TWO: begin
               if (take) begin
                  state_next    = ONE;
                  load_out_skid = 1'b1;
               end
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= EMPTY;
         out_reg  <= '0;
         skid_reg <= '0;
      end else begin
         state <= state_next;
         if (load_out_in)
            out_reg <= in_data;
         else if (load_out_skid)
            out_reg <= skid_reg;
         if (load_skid)
            skid_reg <= in_data;
      end
   end

`ifdef SKID_STATS_EN
   // Saturating count of upstream stall cycles; flush deliberately leaves it alone
   always_ff @(posedge clk) begin
      if (reset)
         stall_cnt <= '0;
      else if (in_valid && !in_ready && stall_cnt != 16'hFFFF)
         stall_cnt <= stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Directed self-checking bench for pipe_skid_buf (N=32); stall counter checks
// are included when SKID_STATS_EN is defined.
module tb_pipe_skid_buf;

   localparam int N = 32;

   logic         clk = 1'b0;
   logic         reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [N-1:0] in_data, out_data;
`ifdef SKID_STATS_EN
   logic [15:0]  stall_cnt;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_skid_buf #(.N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef SKID_STATS_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the active edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'd7; out_ready = 1'b0;

      for (int i = 0; i < 5; i++) begin
         step();
         chk("rst_in_ready", in_ready, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_data", out_data, 0);
      end
`ifdef SKID_STATS_EN
      chk("rst_stall_cnt", stall_cnt, 0);
`endif
      reset = 1'b0; in_valid = 1'b0;
      #1;
      chk("release_in_ready", in_ready, 1);

      // streaming 0..9 with downstream always ready
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_data = i;
         step();
         chk("stream_valid", out_valid, 1);
         chk("stream_data", out_data, i);
         chk("stream_in_ready", in_ready, 1);
      end
      in_valid = 1'b0;
      step();
      chk("stream_drain", out_valid, 0);

      // back-pressure: fill both entries
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd3;
      step();
      chk("bp_one_data", out_data, 3);
      chk("bp_one_ready", in_ready, 1);
      in_data = 32'd4;
      step();
      chk("bp_two_ready", in_ready, 0);
      chk("bp_two_data", out_data, 3);
      in_data = 32'd99;
      step();
      step();
      chk("full_hold_data", out_data, 3);
      chk("full_hold_ready", in_ready, 0);
      chk("full_hold_valid", out_valid, 1);
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      chk("bp_drain1_data", out_data, 4);
      chk("bp_drain1_valid", out_valid, 1);
      chk("bp_drain1_ready", in_ready, 1);
      step();
      chk("bp_drain2_valid", out_valid, 0);
      step();
      chk("empty_take_valid", out_valid, 0);
      chk("empty_take_ready", in_ready, 1);

      // simultaneous accept and take while holding one beat
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd5;
      step();
      chk("sim_hold5", out_data, 5);
      in_data = 32'd6; out_ready = 1'b1;
      step();
      chk("sim_data6", out_data, 6);
      chk("sim_valid", out_valid, 1);
      chk("sim_state_one", in_ready, 1);
      in_valid = 1'b0;
      step();
      chk("sim_drain", out_valid, 0);

      // flush while full
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd8;
      step();
      in_data = 32'd9;
      step();
      chk("fl_full_ready", in_ready, 0);
      flush = 1'b1; in_data = 32'd10;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_valid", out_valid, 0);
      chk("fl_ready", in_ready, 1);

      // flush while empty discards a beat offered with in_ready=1
      flush = 1'b1; in_valid = 1'b1; in_data = 32'd10;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_empty_discard", out_valid, 0);
      step();
      chk("fl_empty_still", out_valid, 0);
      out_ready = 1'b1; in_valid = 1'b1; in_data = 32'd11;
      step();
      in_valid = 1'b0;
      chk("fl_next_data", out_data, 11);
      chk("fl_next_valid", out_valid, 1);
      step();
      chk("fl_next_drain", out_valid, 0);

      // mid-operation reset while full
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd1;
      step();
      in_data = 32'd2;
      step();
      chk("mid_full", in_ready, 0);
      reset = 1'b1; in_valid = 1'b0;
      step();
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_data", out_data, 0);
      chk("mid_rst_ready", in_ready, 0);
      reset = 1'b0;
      #1;
      chk("mid_release_ready", in_ready, 1);

`ifdef SKID_STATS_EN
      chk("stat_after_rst", stall_cnt, 0);
      in_valid = 1'b1; in_data = 32'd20;
      step();
      in_data = 32'd21;
      step();
      chk("stat_fill", stall_cnt, 0);
      for (int i = 0; i < 20; i++) step();
      chk("stat_cnt20", stall_cnt, 20);
      flush = 1'b1; in_valid = 1'b0;
      step();
      flush = 1'b0;
      chk("stat_flush_keeps", stall_cnt, 20);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("stat_rst_clear", stall_cnt, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
